// File: rtl/sap1_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sap1_controller
//  Description : SAP-1 control sequencer. Decodes the one-hot T-state and the
//                opcode nibble into the 12-bit control word, and keeps the
//                execute-phase opcode, halt latch, sticky illegal-state flag
//                and retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module sap1_controller #(
    parameter logic [11:0] CW_IDLE = 12'h3E3,
    parameter int          CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic [5:0]       state,
    input  logic [3:0]       opcode,
    output logic [11:0]      con,
    output logic             HLT,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    // One-hot T-state encodings presented by the ring counter
    localparam logic [5:0] c_T1 = 6'b000001;
    localparam logic [5:0] c_T2 = 6'b000010;
    localparam logic [5:0] c_T3 = 6'b000100;
    localparam logic [5:0] c_T4 = 6'b001000;
    localparam logic [5:0] c_T5 = 6'b010000;
    localparam logic [5:0] c_T6 = 6'b100000;

    // Opcode nibbles; everything not listed behaves as NOP
    localparam logic [3:0] c_OP_LDA = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_OUT = 4'b1110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    // Fetch-phase control words (opcode independent)
    localparam logic [11:0] c_CW_T1 = 12'h5E3;
    localparam logic [11:0] c_CW_T2 = 12'hBE3;
    localparam logic [11:0] c_CW_T3 = 12'h263;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [3:0]       op_q,   op_d;
    logic             halt_q, halt_d;
    logic             err_q,  err_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic             w_state_legal;
    logic [3:0]       w_op_sel;
    logic [1:0]       w_phase;

    // Execute-phase word for a given opcode; phase 0/1/2 = T4/T5/T6
    function automatic logic [11:0] exec_word(input logic [3:0] op, input logic [1:0] phase);
        logic [11:0] w;
        w = CW_IDLE;
        case (op)
            c_OP_LDA: begin
                case (phase)
                    2'd0:    w = 12'h1A3;
                    2'd1:    w = 12'h2C3;
                    default: w = 12'h3E3;
                endcase
            end
            c_OP_ADD: begin
                case (phase)
                    2'd0:    w = 12'h1A3;
                    2'd1:    w = 12'h2E1;
                    default: w = 12'h3C7;
                endcase
            end
            c_OP_SUB: begin
                case (phase)
                    2'd0:    w = 12'h1A3;
                    2'd1:    w = 12'h2E1;
                    default: w = 12'h3CF;
                endcase
            end
            c_OP_OUT: begin
                case (phase)
                    2'd0:    w = 12'h3F2;
                    default: w = 12'h3E3;
                endcase
            end
            default: w = 12'h3E3;
        endcase
        return w;
    endfunction

    // A legal T-state has exactly one bit set
    assign w_state_legal = (state != 6'd0) && ((state & (state - 6'd1)) == 6'd0);

    // Control word: idle in reset, when halted or on an illegal state; T4 uses live opcode
    always_comb begin
        con      = CW_IDLE;
        w_op_sel = op_q;
        w_phase  = 2'd0;
        if (nCLR && !halt_q && w_state_legal) begin
            case (state)
                c_T1: con = c_CW_T1;
                c_T2: con = c_CW_T2;
                c_T3: con = c_CW_T3;
                c_T4: begin
                    w_op_sel = opcode;
                    w_phase  = 2'd0;
                    con      = exec_word(w_op_sel, w_phase);
                end
                c_T5: begin
                    w_phase = 2'd1;
                    con     = exec_word(w_op_sel, w_phase);
                end
                c_T6: begin
                    w_phase = 2'd2;
                    con     = exec_word(w_op_sel, w_phase);
                end
                default: con = CW_IDLE;
            endcase
        end
    end

    // Next-state: illegal states only raise err; T4 latches opcode/halt; T6 retires
    always_comb begin
        op_d   = op_q;
        halt_d = halt_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (!w_state_legal) begin
            err_d = 1'b1;
        end else begin
            if (state == c_T4) begin
                op_d = opcode;
                if (opcode == c_OP_HLT) begin
                    halt_d = 1'b1;
                end
            end
            if ((state == c_T6) && !halt_q) begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            op_q   <= 4'd0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            op_q   <= op_d;
            halt_q <= halt_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign HLT         = halt_q;
    assign err         = err_q;
    assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sap1_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sap1_controller
//  Description : Self-checking bench for sap1_controller. A behavioural model
//                tracks opcode/halt/err/count from the instruction rules and a
//                negedge compare process checks every DUT output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sap1_controller;

    logic        CLK = 1'b0;
    logic        nCLR;
    logic [5:0]  state;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic        HLT;
    logic        err;
    logic [7:0]  instr_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Behavioural model of the architectural state
    logic [3:0] m_op   = 4'd0;
    logic       m_halt = 1'b0;
    logic       m_err  = 1'b0;
    logic [7:0] m_cnt  = 8'd0;

    sap1_controller #(
        .CW_IDLE (12'h3E3),
        .CNT_W   (8)
    ) dut (
        .CLK         (CLK),
        .nCLR        (nCLR),
        .state       (state),
        .opcode      (opcode),
        .con         (con),
        .HLT         (HLT),
        .err         (err),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    // T-step number 1..6 of a one-hot state, 0 if not one-hot
    function automatic int t_index(input logic [5:0] st);
        if ($countones(st) != 1) return 0;
        for (int i = 0; i < 6; i++) if (st[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [5:0] tw(input int t);
        logic [5:0] one;
        one = 6'b000001;
        return one << (t - 1);
    endfunction

    // Required control word from the instruction table
    function automatic logic [11:0] ref_con(input logic rn, input logic halted,
                                            input logic [5:0] st, input logic [3:0] live_op,
                                            input logic [3:0] held_op);
        int          t;
        logic [3:0]  op;
        logic [11:0] w4, w5, w6;
        t = t_index(st);
        if (!rn || halted || t == 0) return 12'h3E3;
        if (t == 1) return 12'h5E3;
        if (t == 2) return 12'hBE3;
        if (t == 3) return 12'h263;
        op = (t == 4) ? live_op : held_op;
        case (op)
            4'h0:    begin w4 = 12'h1A3; w5 = 12'h2C3; w6 = 12'h3E3; end
            4'h1:    begin w4 = 12'h1A3; w5 = 12'h2E1; w6 = 12'h3C7; end
            4'h2:    begin w4 = 12'h1A3; w5 = 12'h2E1; w6 = 12'h3CF; end
            4'hE:    begin w4 = 12'h3F2; w5 = 12'h3E3; w6 = 12'h3E3; end
            default: begin w4 = 12'h3E3; w5 = 12'h3E3; w6 = 12'h3E3; end
        endcase
        return (t == 4) ? w4 : (t == 5) ? w5 : w6;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model update from the instruction rules
    always @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            m_op   <= 4'd0;
            m_halt <= 1'b0;
            m_err  <= 1'b0;
            m_cnt  <= 8'd0;
        end else if (t_index(state) == 0) begin
            m_err <= 1'b1;
        end else begin
            if (t_index(state) == 4) begin
                m_op <= opcode;
                if (opcode == 4'hF) m_halt <= 1'b1;
            end
            if (t_index(state) == 6 && !m_halt) m_cnt <= m_cnt + 8'd1;
        end
    end

    // Compare every output against the model, mid-cycle
    always @(negedge CLK) begin
        if (chk_en) begin
            check("con",         con,                ref_con(nCLR, m_halt, state, opcode, m_op));
            check("HLT",         {11'd0, HLT},       {11'd0, m_halt});
            check("err",         {11'd0, err},       {11'd0, m_err});
            check("instr_count", {4'd0, instr_count}, {4'd0, m_cnt});
        end
    end

    // One clock step: drive at posedge+1, optional literal con check at posedge+4
    task automatic step(input logic [5:0] st, input logic [3:0] op,
                        input logic [11:0] lit, input bit chk_lit);
        @(posedge CLK);
        #1;
        state  = st;
        opcode = op;
        #3;
        if (chk_lit) check("con_literal", con, lit);
    endtask

    // Asynchronous reset pulse dropped between clock edges
    task automatic do_reset();
        nCLR   = 1'b0;
        chk_en = 1'b1;
        #0.5;
        check("rst_con",   con,                12'h3E3);
        check("rst_HLT",   {11'd0, HLT},       12'd0);
        check("rst_err",   {11'd0, err},       12'd0);
        check("rst_count", {4'd0, instr_count}, 12'd0);
        state  = tw(1);
        opcode = 4'd0;
        @(posedge CLK);
        #1;
        nCLR = 1'b1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] op_late,
                             input logic [11:0] e4, input logic [11:0] e5,
                             input logic [11:0] e6, input bit lit);
        step(tw(1), op,      12'h5E3, lit);
        step(tw(2), op,      12'hBE3, lit);
        step(tw(3), op,      12'h263, lit);
        step(tw(4), op,      e4,      lit);
        step(tw(5), op_late, e5,      lit);
        step(tw(6), op_late, e6,      lit);
    endtask

    task automatic random_instr();
        logic [3:0] op;
        logic [5:0] st;
        op = 4'($urandom_range(0, 15));
        for (int t = 1; t <= 6; t++) begin
            st = tw(t);
            if ($urandom_range(0, 39) == 0) begin
                do st = 6'($urandom); while ($countones(st) == 1);
            end
            step(st, (t == 4) ? op : 4'($urandom), 12'h000, 1'b0);
        end
        if ($urandom_range(0, 99) == 0 || (m_halt && $urandom_range(0, 3) == 0)) begin
            do_reset();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nCLR   = 1'b1;
        state  = tw(1);
        opcode = 4'd0;
        #3;
        do_reset();

        // LDA fetch and execute
        run_instr(4'h0, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3, 1'b1);
        step(tw(1), 4'h0, 12'h5E3, 1'b1);
        check("count_after_lda", {4'd0, instr_count}, 12'd1);

        // ADD then SUB, with opcode disturbed after T4
        run_instr(4'h1, 4'hE, 12'h1A3, 12'h2E1, 12'h3C7, 1'b1);
        run_instr(4'h2, 4'hE, 12'h1A3, 12'h2E1, 12'h3CF, 1'b1);
        step(tw(1), 4'h0, 12'h5E3, 1'b1);
        check("count_after_sub", {4'd0, instr_count}, 12'd3);

        // ADD, OUT, then HLT
        do_reset();
        run_instr(4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7, 1'b1);
        run_instr(4'hE, 4'hE, 12'h3F2, 12'h3E3, 12'h3E3, 1'b1);
        step(tw(1), 4'hF, 12'h5E3, 1'b1);
        step(tw(2), 4'hF, 12'hBE3, 1'b1);
        step(tw(3), 4'hF, 12'h263, 1'b1);
        step(tw(4), 4'hF, 12'h3E3, 1'b1);
        step(tw(5), 4'h1, 12'h3E3, 1'b1);
        check("halt_set", {11'd0, HLT}, 12'd1);
        for (int r = 0; r < 2; r++)
            for (int t = 1; t <= 6; t++) step(tw(t), 4'($urandom), 12'h3E3, 1'b1);
        check("count_halted", {4'd0, instr_count}, 12'd2);

        // Reset while halted
        do_reset();

        // Illegal state
        step(tw(1), 4'h0, 12'h5E3, 1'b1);
        step(6'b000011, 4'h0, 12'h3E3, 1'b1);
        step(tw(2), 4'h0, 12'hBE3, 1'b1);
        check("err_set", {11'd0, err}, 12'd1);
        run_instr(4'h0, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3, 1'b1);
        check("err_sticky", {11'd0, err}, 12'd1);

        // Counter wrap over 256 NOPs
        do_reset();
        for (int i = 0; i < 256; i++)
            run_instr(4'h5, 4'h5, 12'h3E3, 12'h3E3, 12'h3E3, 1'b1);
        step(tw(1), 4'h5, 12'h5E3, 1'b1);
        check("count_wrap", {4'd0, instr_count}, 12'd0);

        // Reset during T5 of an ADD
        run_instr(4'h5, 4'h5, 12'h3E3, 12'h3E3, 12'h3E3, 1'b1);
        step(tw(1), 4'h1, 12'h5E3, 1'b1);
        check("count_before_midreset", {4'd0, instr_count}, 12'd1);
        step(tw(2), 4'h1, 12'hBE3, 1'b1);
        step(tw(3), 4'h1, 12'h263, 1'b1);
        step(tw(4), 4'h1, 12'h1A3, 1'b1);
        step(tw(5), 4'h1, 12'h2E1, 1'b1);
        do_reset();

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) random_instr();

        @(posedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
